// File: rtl/turbo_pkg.sv
// Shared types and helpers for the turbo-encoder output serializer.
package turbo_pkg;

    localparam int TAIL_BITS   = 4;
    localparam int NUM_STREAMS = 3;

    typedef enum logic {
        IDLE,
        SEND
    } serializer_state_t;

    // [stream][j] is the tail bit transmitted at position K+j of dk<stream>
    typedef logic [NUM_STREAMS-1:0][TAIL_BITS-1:0] tail_t;

    // Raw tail arrives as {z'K+2..z'K, x'K+2..x'K, zK+2..zK, xK+2..xK};
    // interleave it into the three dk streams' termination ordering.
    function automatic tail_t tail_map(input logic [11:0] raw);
        tail_t      t;
        logic [2:0] x;
        logic [2:0] z;
        logic [2:0] xp;
        logic [2:0] zp;
        {zp, xp, z, x} = raw;
        t[0] = {zp[1], xp[0], z[1], x[0]};
        t[1] = {xp[2], zp[0], x[2], z[0]};
        t[2] = {zp[2], xp[1], z[2], x[1]};
        return t;
    endfunction

endpackage

// File: rtl/tail_reorder.sv
// Combinational 12->12 permutation of the raw trellis tail into dk order.
module tail_reorder
    import turbo_pkg::*;
(
    input  logic [11:0] raw,
    output logic [11:0] ordered
);

    assign ordered = tail_map(raw);

endmodule

// File: rtl/turbo_stream_serializer.sv
// Three-stream parallel-to-serial stage: captures one code block, then emits
// W bits per stream per beat with last marker and partial-beat bit count.
// Optional: define TURBO_TAIL_REORDER_EN to source bits K..K+3 from i_tail.
module turbo_stream_serializer
    import turbo_pkg::*;
#(
    parameter int K_MAX = 40,
    parameter int W     = 1
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic [K_MAX+3:0]             i_stream1,
    input  logic [K_MAX+3:0]             i_stream2,
    input  logic [K_MAX+3:0]             i_stream3,
    input  logic [11:0]                  i_tail,
    input  logic [$clog2(K_MAX+5)-1:0]   i_k,
    input  logic                         i_valid,
    output logic                         o_ready,
    output logic [W-1:0]                 o_dk0,
    output logic [W-1:0]                 o_dk1,
    output logic [W-1:0]                 o_dk2,
    output logic                         o_valid,
    input  logic                         i_ready,
    output logic                         o_last,
    output logic [$clog2(W+1)-1:0]       o_nbits,
    output logic                         o_err
);

    localparam int BL = K_MAX + TAIL_BITS;
    localparam int KW = $clog2(K_MAX + 5);
    localparam int PW = $clog2(K_MAX + 4 + W);
    localparam int NW = $clog2(W + 1);

    serializer_state_t                  state_q, state_n;
    logic [NUM_STREAMS-1:0][BL-1:0]     buf_q, buf_n;
    logic [PW-1:0]                      base_q, base_n;
    logic [PW-1:0]                      len_q, len_n;
    logic                               err_n;
    logic                               k_bad;
    logic [KW-1:0]                      k_eff;
    logic [NUM_STREAMS-1:0][W-1:0]      lanes_n;
    logic                               last_n;
    logic [NW-1:0]                      nbits_n;

`ifdef TURBO_TAIL_REORDER_EN
    logic [PW-1:0] k_q, k_n;
    tail_t         tail_q, tail_n;
    tail_t         tail_ord;

    tail_reorder u_tail_reorder (
        .raw     (i_tail),
        .ordered (tail_ord)
    );
`else
    // Tail comes straight from the streams in this build.
    logic unused_tail;
    assign unused_tail = ^i_tail;
`endif

    // Illegal block sizes fall back to the largest supported block.
    assign k_bad = (i_k == '0) || (i_k > KW'(K_MAX));
    assign k_eff = k_bad ? KW'(K_MAX) : i_k;

    // Next state: capture a block in IDLE, advance the pointer per accepted beat.
    always_comb begin
        state_n = state_q;
        buf_n   = buf_q;
        base_n  = base_q;
        len_n   = len_q;
        err_n   = o_err;
`ifdef TURBO_TAIL_REORDER_EN
        k_n     = k_q;
        tail_n  = tail_q;
`endif
        case (state_q)
            IDLE: begin
                if (i_valid) begin
                    state_n = SEND;
                    buf_n   = {i_stream3, i_stream2, i_stream1};
                    base_n  = '0;
                    len_n   = PW'(k_eff) + PW'(TAIL_BITS);
                    err_n   = k_bad;
`ifdef TURBO_TAIL_REORDER_EN
                    k_n     = PW'(k_eff);
                    tail_n  = tail_ord;
`endif
                end
            end
            SEND: begin
                if (i_ready) begin
                    base_n = base_q + PW'(W);
                    if (o_last) state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Beat contents for the next cycle, computed from next-state so outputs are pure flops.
    always_comb begin
        logic [PW-1:0] pos;
        logic          bit_v;
        lanes_n = '0;
        last_n  = 1'b0;
        nbits_n = '0;
        pos     = '0;
        bit_v   = 1'b0;
        if (state_n == SEND) begin
            last_n  = (base_n + PW'(W)) >= len_n;
            nbits_n = last_n ? NW'(len_n - base_n) : NW'(W);
            for (int j = 0; j < W; j++) begin
                pos = base_n + PW'(j);
                for (int s = 0; s < NUM_STREAMS; s++) begin
                    bit_v = 1'b0;
                    for (int i = 0; i < BL; i++)
                        if (pos == PW'(i)) bit_v = buf_n[s][i];
`ifdef TURBO_TAIL_REORDER_EN
                    if (pos >= k_n)
                        for (int t = 0; t < TAIL_BITS; t++)
                            if ((pos - k_n) == PW'(t)) bit_v = tail_n[s][t];
`endif
                    // Lanes past the end of the block are forced to zero.
                    lanes_n[s][j] = (pos < len_n) ? bit_v : 1'b0;
                end
            end
        end
    end

    // State, buffers and registered outputs.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= IDLE;
            buf_q   <= '0;
            base_q  <= '0;
            len_q   <= '0;
`ifdef TURBO_TAIL_REORDER_EN
            k_q     <= '0;
            tail_q  <= '0;
`endif
            o_ready <= 1'b1;
            o_valid <= 1'b0;
            o_last  <= 1'b0;
            o_nbits <= '0;
            o_dk0   <= '0;
            o_dk1   <= '0;
            o_dk2   <= '0;
            o_err   <= 1'b0;
        end else begin
            state_q <= state_n;
            buf_q   <= buf_n;
            base_q  <= base_n;
            len_q   <= len_n;
`ifdef TURBO_TAIL_REORDER_EN
            k_q     <= k_n;
            tail_q  <= tail_n;
`endif
            o_ready <= (state_n == IDLE);
            o_valid <= (state_n == SEND);
            o_last  <= last_n;
            o_nbits <= nbits_n;
            o_dk0   <= lanes_n[0];
            o_dk1   <= lanes_n[1];
            o_dk2   <= lanes_n[2];
            o_err   <= err_n;
        end
    end

endmodule
